// File: rtl/sdbp_pkg.sv
// sdbp_pkg -- shared constants and FSM encodings for the SDBP frame receiver.
//   NUM_LEDS : default number of LED words per frame
//   WORD_W   : default bits per LED word
//   ADDR_W   : writer address width (address 0 means idle)
//   cap_state_t / sh_state_t : capture and shift FSM encodings
package sdbp_pkg;

  localparam int NUM_LEDS = 360;
  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 10;

  typedef enum logic {
    CP_WAIT    = 1'b0,
    CP_CAPTURE = 1'b1
  } cap_state_t;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_LOAD  = 2'd1,
    SH_SHIFT = 2'd2,
    SH_LATCH = 2'd3
  } sh_state_t;

endpackage

// File: rtl/sdbp_frame_buf.sv
// sdbp_frame_buf -- two-bank frame store, one write port and one read port.
// The read is registered: data for i_rd_idx appears one clock later.
// Contents are deliberately not reset.
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_bank  : bank receiving the write
//   i_wr_idx   : word index of the write
//   i_wr_data  : write data
//   i_rd_bank  : bank being read
//   i_rd_idx   : word index of the read
//   o_rd_data  : registered read data
module sdbp_frame_buf #(
  parameter int DEPTH  = 360,
  parameter int WORD_W = 16,
  parameter int IW     = 9
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [IW-1:0]     i_wr_idx,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [IW-1:0]     i_rd_idx,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem0 [DEPTH];
  logic [WORD_W-1:0] r_mem1 [DEPTH];
  logic [WORD_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_wr_bank) r_mem0[i_wr_idx] <= i_wr_data;
    if (i_wr_en &&  i_wr_bank) r_mem1[i_wr_idx] <= i_wr_data;
    r_rd_data <= i_rd_bank ? r_mem1[i_rd_idx] : r_mem0[i_rd_idx];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sdbp_frame_rx.sv
// sdbp_frame_rx -- captures SDBP writer frames into a ping-pong buffer and
// shifts completed frames serially to an LED driver, MSB first, then latches.
//
// Optional feature: define SDBP_RX_GAMMA_EN to square the upper 8 bits of each
// word on its way into the shifter (16-bit result). Undefined: words pass
// through unmodified and no multiplier exists.
//
// Ports:
//   clk        : single clock, all logic on the rising edge
//   rst        : asynchronous active-high reset
//   sdbpflag   : frame-start flag, rising edge arms/restarts capture
//   wtaddr     : writer address, 1..NUM_LEDS valid, 0 idle
//   wtdina     : writer data, one cycle behind wtaddr
//   led_sclk   : serial clock (clk/2 while shifting)
//   led_sdo    : serial data, changes with led_sclk falling
//   led_lat    : LAT_W-cycle latch pulse after the last bit
//   frame_done : one-cycle pulse as led_lat drops
//   overrun    : one-cycle pulse when a completed capture is dropped
//   frame_err  : one-cycle pulse when a capture is restarted
module sdbp_frame_rx
  import sdbp_pkg::*;
#(
  parameter int NUM_LEDS = sdbp_pkg::NUM_LEDS,
  parameter int WORD_W   = sdbp_pkg::WORD_W,
  parameter int LAT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdbpflag,
  input  logic [ADDR_W-1:0] wtaddr,
  input  logic [WORD_W-1:0] wtdina,
  output logic              led_sclk,
  output logic              led_sdo,
  output logic              led_lat,
  output logic              frame_done,
  output logic              overrun,
  output logic              frame_err
);

  localparam int IW  = $clog2(NUM_LEDS);
  localparam int BW  = $clog2(WORD_W);
  localparam int LCW = (LAT_W > 1) ? $clog2(LAT_W) : 1;

  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NUM_LEDS);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(NUM_LEDS - 1);
  localparam logic [BW-1:0]     B_TOP  = BW'(WORD_W - 1);
  localparam logic [LCW-1:0]    L_LAST = LCW'(LAT_W - 1);

  // Word transform applied between buffer read and shifter load.
  function automatic logic [WORD_W-1:0] f_map(input logic [WORD_W-1:0] w);
`ifdef SDBP_RX_GAMMA_EN
    logic [15:0] p;
    p = {8'd0, w[WORD_W-1 -: 8]} * {8'd0, w[WORD_W-1 -: 8]};
    return WORD_W'(p);
`else
    return w;
`endif
  endfunction

  // ---------------- capture side ----------------
  cap_state_t        r_cst;
  logic              r_flag_d;
  logic [ADDR_W-1:0] r_a_d;
  logic              r_sel;     // bank owned by capture; shifter reads ~r_sel

  sh_state_t         r_sst;

  logic w_rise, w_in_cap, w_wr_en, w_done, w_sh_idle, w_swap;
  logic [IW-1:0] w_wr_idx;

  assign w_rise    = sdbpflag & ~r_flag_d;
  assign w_in_cap  = (r_cst == CP_CAPTURE);
  assign w_wr_en   = w_in_cap && (r_a_d != '0) && (r_a_d <= A_LAST);
  assign w_wr_idx  = IW'(r_a_d - A_ONE);
  // A restart edge takes precedence over completion in the same cycle.
  assign w_done    = w_in_cap && !w_rise && (r_a_d == A_LAST);
  assign w_sh_idle = (r_sst == SH_IDLE);
  assign w_swap    = w_done && w_sh_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cst     <= CP_WAIT;
      r_flag_d  <= 1'b0;
      r_a_d     <= '0;
      r_sel     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_flag_d  <= sdbpflag;
      r_a_d     <= wtaddr;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (r_cst)
        CP_WAIT: begin
          if (w_rise) r_cst <= CP_CAPTURE;
        end
        CP_CAPTURE: begin
          if (w_rise) begin
            // Restart into the same bank; later writes overwrite it.
            frame_err <= 1'b1;
          end else if (w_done) begin
            r_cst <= CP_WAIT;
            if (w_sh_idle) r_sel   <= ~r_sel;
            else           overrun <= 1'b1;  // shifter busy: drop this frame
          end
        end
        default: r_cst <= CP_WAIT;
      endcase
    end
  end

  // ---------------- frame buffer ----------------
  logic [IW-1:0]     w_rd_idx;
  logic [WORD_W-1:0] w_rd_data;
  logic [WORD_W-1:0] w_rd_map;

  logic [ADDR_W-1:0] r_word;
  logic [BW-1:0]     r_bit;
  logic [LCW-1:0]    r_lcnt;
  logic              r_ph;      // 0: sclk low half of a bit, 1: high half
  logic [WORD_W-1:0] r_shreg;

  // While shifting, keep the next word addressed so it is ready by the time
  // the current word's last bit ends. Outside SHIFT, word 0 is addressed.
  always_comb begin
    w_rd_idx = '0;
    if (r_sst == SH_SHIFT && r_word != W_LAST) w_rd_idx = IW'(r_word + A_ONE);
  end

  sdbp_frame_buf #(
    .DEPTH  (NUM_LEDS),
    .WORD_W (WORD_W),
    .IW     (IW)
  ) u_buf (
    .i_clk     (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_bank (r_sel),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (wtdina),
    .i_rd_bank (~r_sel),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  assign w_rd_map = f_map(w_rd_data);

  // ---------------- shift side ----------------
  // LOAD spends one cycle addressing word 0 in the new bank and one cycle
  // taking the registered read data into the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sst      <= SH_IDLE;
      r_word     <= '0;
      r_bit      <= '0;
      r_lcnt     <= '0;
      r_ph       <= 1'b0;
      r_shreg    <= '0;
      led_sclk   <= 1'b0;
      led_sdo    <= 1'b0;
      led_lat    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_sst)
        SH_IDLE: begin
          r_ph <= 1'b0;
          if (w_swap) r_sst <= SH_LOAD;
        end
        SH_LOAD: begin
          if (!r_ph) begin
            r_ph <= 1'b1;
          end else begin
            r_ph    <= 1'b0;
            r_word  <= '0;
            r_bit   <= B_TOP;
            r_shreg <= w_rd_map;
            led_sdo <= w_rd_map[WORD_W-1];
            r_sst   <= SH_SHIFT;
          end
        end
        SH_SHIFT: begin
          if (!r_ph) begin
            r_ph     <= 1'b1;
            led_sclk <= 1'b1;
          end else begin
            // sclk falls here; data moves to the next bit on the same edge
            r_ph     <= 1'b0;
            led_sclk <= 1'b0;
            if (r_bit != '0) begin
              r_bit   <= r_bit - 1'b1;
              r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
              led_sdo <= r_shreg[WORD_W-2];
            end else if (r_word == W_LAST) begin
              r_word  <= '0;
              r_bit   <= '0;
              r_lcnt  <= '0;
              led_sdo <= 1'b0;
              led_lat <= 1'b1;
              r_sst   <= SH_LATCH;
            end else begin
              r_word  <= r_word + A_ONE;
              r_bit   <= B_TOP;
              r_shreg <= w_rd_map;
              led_sdo <= w_rd_map[WORD_W-1];
            end
          end
        end
        SH_LATCH: begin
          if (r_lcnt == L_LAST) begin
            r_lcnt     <= '0;
            led_lat    <= 1'b0;
            frame_done <= 1'b1;
            r_sst      <= SH_IDLE;
          end else begin
            r_lcnt <= r_lcnt + 1'b1;
          end
        end
        default: r_sst <= SH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdbp_frame_rx.sv
// tb_sdbp_frame_rx -- scoreboard bench for sdbp_frame_rx at default parameters.
// Expected shifted words are queued when a capture is issued; a monitor
// deserialises led_sdo on led_sclk rising and pops/compares each word, and
// also checks latch width, frame length and pulse alignment.
module tb_sdbp_frame_rx;

  localparam int N    = 360;
  localparam int W    = 16;
  localparam int LAT  = 4;
  localparam int BITS = N * W;

`ifdef SDBP_RX_GAMMA_EN
  localparam logic [15:0] ALLF_EXP = 16'hFE01;
`else
  localparam logic [15:0] ALLF_EXP = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdbpflag = 1'b0;
  logic [9:0]  wtaddr = '0;
  logic [15:0] wtdina = '0;
  logic        led_sclk, led_sdo, led_lat, frame_done, overrun, frame_err;

  sdbp_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .sdbpflag   (sdbpflag),
    .wtaddr     (wtaddr),
    .wtdina     (wtdina),
    .led_sclk   (led_sclk),
    .led_sdo    (led_sdo),
    .led_lat    (led_lat),
    .frame_done (frame_done),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  int bits_total = 0, frame_bits = 0, nb = 0, cyc = 0, t0 = 0, lat_run = 0;
  int lat_pulses = 0, done_pulses = 0, ovr_rise = 0, ovr_hi = 0, err_rise = 0, err_hi = 0;
  logic [15:0] acc = '0;
  logic p_sclk = 1'b0, p_lat = 1'b0, p_ovr = 1'b0, p_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] xmap(input logic [15:0] w);
`ifdef SDBP_RX_GAMMA_EN
    return {8'd0, w[15:8]} * {8'd0, w[15:8]};
`else
    return w;
`endif
  endfunction

  function automatic logic [15:0] dat(input int mode, input int a);
    case (mode)
      0:       return 16'(a * 256);
      1:       return 16'h0F0F;
      2:       return 16'hFFFF;
      3:       return 16'(a * 291) ^ 16'hA5A5;
      default: return 16'h5555;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flag_pulse();
    sdbpflag = 1'b1;
    tick();
    sdbpflag = 1'b0;
    tick();
  endtask

  // Drives addresses first..last with data one cycle behind; raises
  // sdbpflag in the iteration a == flag_at (0 = never).
  task automatic capture(input int mode, input int first, input int last, input int flag_at);
    for (int a = first; a <= last + 1; a++) begin
      wtaddr   = (a <= last) ? 10'(a) : 10'd0;
      wtdina   = (a > first) ? dat(mode, a - 1) : 16'h0000;
      sdbpflag = (a == flag_at);
      tick();
    end
    wtaddr   = '0;
    wtdina   = '0;
    sdbpflag = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input int lim);
    int n;
    n = 0;
    while (done_pulses < tgt && n < lim) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(done_pulses >= tgt), 32'd1);
  endtask

  // Monitor / scoreboard consumer
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      nb = 0; frame_bits = 0; lat_run = 0;
      p_sclk = 1'b0; p_lat = 1'b0; p_ovr = 1'b0; p_err = 1'b0;
    end else begin
      if (led_sclk && !p_sclk) begin
        if (frame_bits == 0) t0 = cyc;
        acc = {acc[14:0], led_sdo};
        nb++; frame_bits++; bits_total++;
        if (nb == W) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL word_unexpected act=%04h req=none", acc);
          end else begin
            chk("word", 32'(acc), 32'(exp_q.pop_front()));
          end
        end
      end
      if (led_lat && !p_lat) begin
        chk("frame_bits", frame_bits, BITS);
        chk("frame_span", cyc - t0, 2 * BITS - 1);
        frame_bits = 0;
      end
      if (led_lat) lat_run++;
      if (!led_lat && p_lat) begin
        lat_pulses++;
        chk("lat_width", lat_run, LAT);
        lat_run = 0;
      end
      if (frame_done) begin
        done_pulses++;
        chk("done_align", {30'd0, p_lat, led_lat}, 32'b10);
      end
      if (overrun) ovr_hi++;
      if (overrun && !p_ovr) ovr_rise++;
      if (frame_err) err_hi++;
      if (frame_err && !p_err) err_rise++;
      p_sclk = led_sclk; p_lat = led_lat; p_ovr = overrun; p_err = frame_err;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int saved;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {26'd0, led_sclk, led_sdo, led_lat, frame_done, overrun, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (50) tick();
    chk("no_shift_before_capture", bits_total, 0);

    // frame A (addr*256), then a second capture while A shifts -> overrun
    for (int a = 1; a <= N; a++) exp_q.push_back(xmap(dat(0, a)));
    flag_pulse();
    capture(0, 1, N, 0);
    repeat (2000) tick();
    flag_pulse();
    capture(4, 1, N, 0);
    repeat (3) tick();
    chk("overrun_rise", ovr_rise, 1);
    chk("overrun_width", ovr_hi, 1);
    wait_done(1, 13000);
    repeat (200) tick();
    chk("A_lat_count", lat_pulses, 1);
    chk("A_done_count", done_pulses, 1);
    chk("A_bits", bits_total, BITS);
    chk("A_queue_empty", exp_q.size(), 0);
    chk("A_no_err", err_rise, 0);

    // restart at a_d=100; only restarted data may appear
    flag_pulse();
    capture(1, 1, 100, 101);
    repeat (2) tick();
    chk("err_rise", err_rise, 1);
    chk("err_width", err_hi, 1);
    for (int a = 1; a <= N; a++) exp_q.push_back(ALLF_EXP);
    capture(2, 1, N, 0);
    wait_done(2, 13000);
    repeat (20) tick();
    chk("B_queue_empty", exp_q.size(), 0);
    chk("B_lat_count", lat_pulses, 2);

    // reset during a shift, around bit 3000 while sclk is high
    for (int a = 1; a <= N; a++) exp_q.push_back(ALLF_EXP);
    flag_pulse();
    capture(2, 1, N, 0);
    n = 0;
    while (!(frame_bits >= 3000 && led_sclk) && n < 20000) begin
      tick();
      n++;
    end
    chk("bit3000_wait", 32'(n < 20000), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {26'd0, led_sclk, led_sdo, led_lat, frame_done, overrun, frame_err}, 32'd0);
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    repeat (100) tick();
    chk("C_no_lat", lat_pulses, 2);
    chk("C_no_done", done_pulses, 2);

    // addresses 0 and 361 after arming: nothing happens, FSM stays in CAPTURE
    saved = bits_total;
    flag_pulse();
    wtaddr = 10'd0;
    repeat (20) tick();
    wtaddr = 10'd361;
    wtdina = 16'hDEAD;
    repeat (20) tick();
    wtaddr = 10'd0;
    wtdina = 16'h0000;
    repeat (10) tick();
    chk("idle_addr_no_shift", bits_total, saved);
    // no new flag edge: completes only if capture stayed armed
    for (int a = 1; a <= N; a++) exp_q.push_back(xmap(dat(3, a)));
    capture(3, 1, N, 0);
    wait_done(3, 13000);
    repeat (20) tick();
    chk("D_queue_empty", exp_q.size(), 0);
    chk("D_lat_count", lat_pulses, 3);
    chk("D_done_count", done_pulses, 3);
    chk("final_overrun", ovr_rise, 1);
    chk("final_err", err_rise, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdbp_frame_rx.md
SDBP_FRAME_RX -- requirements
Module: sdbp_frame_rx

Interface
REQ-001 Parameter NUM_LEDS, default 360, number of words per frame.
REQ-002 Parameter WORD_W, default 16, bits per LED word.
REQ-003 Parameter LAT_W, default 4, led_lat pulse width in clk cycles.
REQ-004 clk  input  1  single clock, 25 MHz, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sdbpflag  input  1  frame-start flag from the writer; a rising edge arms capture.
REQ-007 wtaddr  input  10  writer address; 1..NUM_LEDS valid, 0 idle.
REQ-008 wtdina  input  WORD_W  writer data; registered one cycle behind wtaddr.
REQ-009 led_sclk  output  1  serial clock to the LED driver, clk/2 while shifting, else 0.
REQ-010 led_sdo  output  1  serial data, MSB first, changes on the led_sclk falling edge.
REQ-011 led_lat  output  1  latch pulse after the last bit of a frame.
REQ-012 frame_done  output  1  one-cycle pulse on led_lat deassertion.
REQ-013 overrun  output  1  one-cycle pulse when a captured frame is dropped.
REQ-014 frame_err  output  1  one-cycle pulse when a capture is aborted.

Function
REQ-015 Two NUM_LEDS x WORD_W buffers in ping-pong: capture side writes one, shift side reads the other.
REQ-016 Capture FSM states: WAIT, CAPTURE; WAIT->CAPTURE on sdbpflag rising edge (registered edge detect).
REQ-017 In CAPTURE, wtaddr is delayed one cycle (a_d); when 1 <= a_d <= NUM_LEDS, wtdina is written to index a_d-1.
REQ-018 a_d == NUM_LEDS write completes the frame; CAPTURE->WAIT, request swap in the same cycle.
REQ-019 a_d == 0 or a_d > NUM_LEDS: no write, no state change.
REQ-020 sdbpflag rising edge while in CAPTURE: restart capture in the same buffer, pulse frame_err.
REQ-021 Swap request with shift FSM in IDLE: swap buffers, start shifting next cycle.
REQ-022 Swap request with shift FSM busy: frame discarded, no swap, pulse overrun; the shifting frame is unaffected.
REQ-023 Shift FSM states: IDLE, LOAD, SHIFT, LATCH; IDLE->LOAD on swap; LOAD reads word 0 (one-cycle read latency) into a WORD_W shift register.
REQ-024 SHIFT: each bit occupies 2 clk; led_sdo valid while led_sclk low, led_sclk high in the second cycle; next word prefetched during the current word's final bit.
REQ-025 After bit 0 of word NUM_LEDS-1: SHIFT->LATCH, led_sclk=0, led_lat=1 for LAT_W cycles, then frame_done pulse and ->IDLE.
REQ-026 Frame serial time = NUM_LEDS*WORD_W*2 + LAT_W + 2 cycles (11526 at defaults).
REQ-027 Word and bit counters wrap to 0 on frame end; no counter overflows at NUM_LEDS <= 1023.

Reset
REQ-028 rst asserted: both FSMs to WAIT/IDLE, counters 0, buffer select 0, all outputs 0, immediately (asynchronous).
REQ-029 Buffer contents are not reset; a frame is never shifted before a full capture completes.
REQ-030 rst mid-shift truncates the frame with no led_lat pulse.

Configuration
REQ-031 Macro SDBP_RX_GAMMA_EN defined: each shifted word is replaced by (word[15:8])*(word[15:8]) as 16 bits, computed in LOAD/prefetch with no added latency.
REQ-032 Macro undefined: words shifted unmodified; no multiplier instantiated.

Structure
REQ-033 Shared package sdbp_pkg holds NUM_LEDS, WORD_W, the address width (10), and capture/shift FSM state encodings.
REQ-034 One sub-module, sdbp_frame_buf (dual-bank, registered read, one write and one read port); FSMs and shifter in the top.

Verification
REQ-035 Reset, then one frame of wtaddr 1..360 with wtdina=addr*256 -> 5760 bits shifted, word 0 = 0x0100, word 359 = 0x6800 (upper 8 bits of 360*256 truncated), one led_lat of 4 cycles, one frame_done.
REQ-036 All words 0xFFFF with SDBP_RX_GAMMA_EN -> every shifted word 0xFE01; without the macro -> 0xFFFF.
REQ-037 Second sdbpflag edge at a_d=100 -> frame_err pulse; the frame later shifted contains only data from the restarted capture.
REQ-038 Second complete capture 2000 cycles after the first swap -> overrun pulse; first frame shifts intact; no second led_lat.
REQ-039 rst asserted at bit 3000 of a shift -> led_sclk/led_sdo/led_lat 0 in the same cycle; next full capture shifts normally.
REQ-040 wtaddr held at 0 and 361 with sdbpflag edge -> no writes, no shift, FSM remains CAPTURE.
